hitchhike_tx_sched: RTL and testbench
=====================================

# hitchhike_tx_sched

Frame scheduler and serializer for the backscatter transmit path. It arbitrates between two payload requesters with round-robin fairness and builds a fixed 48-bit frame: preamble, header, 10-bit payload, tail. It emits the frame bit-serially, holding each bit for a programmable number of clocks, and enforces a minimum idle gap between frames. It sits between the sensor/beacon logic and the tag modulator input.

## Interface
- BIT_PERIOD, 50: clocks per transmitted bit; legal range 2..65535.
- GAP_CYCLES, 100: idle clocks after each completed frame; legal range 1..65535.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  transmit enable; low aborts any frame in progress.
- req_a  in  1  request from source A (sensor), held until ack_a.
- data_a  in  10  source A payload; sampled on grant edge.
- req_b  in  1  request from source B (beacon), held until ack_b.
- data_b  in  10  source B payload; sampled on grant edge.
- ack_a  out  1  one-cycle grant pulse to A.
- ack_b  out  1  one-cycle grant pulse to B.
- bit_out  out  1  serial frame bit to modulator.
- bit_strobe  out  1  one-cycle pulse in the first cycle of each bit.
- tx_active  out  1  high while a frame is being serialized.
- done  out  1  one-cycle pulse after the last bit of a completed frame.

## Operation
- States:
  - IDLE: waiting for a request.
  - SEND: serializing the frame.
  - GAP: enforcing the inter-frame idle time.
- Reset values: all outputs 0; state IDLE; seq = 0; rr_last = B, so A wins the first tie.
- Frame layout, bit 0 first, each field MSB first:
  - bits 0–23: preamble 24'h929292.
  - bits 24–31: header {src, seq[2:0], 4'b0010}, where src = 0 for A and 1 for B.
  - bits 32–41: latched payload.
  - bits 42–47: tail, all 0 (see Configuration for bit 47).
- IDLE:
  - With enable high and exactly one req asserted, that source is granted.
  - If both are asserted, the source not equal to rr_last is granted; rr_last is then updated.
  - On the grant edge: payload and src are latched, ack pulses, state goes to SEND, bit index = 0, bit counter = 0.
  - A req that drops before being granted is ignored.
- SEND:
  - Bit counter counts 0..BIT_PERIOD-1, then wraps; the bit index increments on each wrap.
  - bit_out shows frame[index]; bit_strobe is high when counter == 0.
  - At the wrap of index 47: done pulses, seq increments modulo 8 (7 wraps to 0), state goes to GAP, bit_out = 0, tx_active = 0.
- GAP: counts GAP_CYCLES clocks, then goes to IDLE. Requests are held pending and are not acked during GAP.
- Abort: enable low in any state forces IDLE on the next edge.
  - bit_out, tx_active and bit_strobe go to 0; no done pulse.
  - seq is unchanged; the GAP is skipped.
  - The aborted requester was already acked and is not re-served.
- Both acks are never asserted in the same cycle.
- Asynchronous reset mid-frame: all outputs go to 0 immediately; seq returns to 0.

## Timing
- Grant at edge k:
  - ack, tx_active, bit_strobe and bit_out = frame[0] are visible after edge k.
  - Bit i is held for the cycles after edges k+i·BIT_PERIOD through k+(i+1)·BIT_PERIOD−1.
- done is visible after edge k+48·BIT_PERIOD for one cycle; tx_active falls at the same edge.
- The earliest next grant is at edge k+48·BIT_PERIOD+GAP_CYCLES+1: GAP_CYCLES clocks of GAP, then one IDLE sampling edge.
- Frame duration is exactly 48·BIT_PERIOD clocks. The bit counter and GAP counter are 16 bits.
- Request-to-ack latency from IDLE is 1 edge.

## Configuration
- TX_PARITY_EN:
  - Defined: frame bit 47 = even parity over header and payload (XOR of bits 24–41).
  - Undefined: bit 47 = 0.
- All other behaviour is identical in both builds.

## Test plan
Bench settings: BIT_PERIOD=4, GAP_CYCLES=8, TX_PARITY_EN defined.

- **Single A frame.** req_a with data_a=10'h2AA after reset → ack_a after 1 edge; bit_out sequence 929292, 02, 1010101010, 000000 (parity 0); 48 strobes 4 clocks apart; done at 192 clocks after grant.
- **Second frame, seq increment.** Second req_a with data_a=10'h001 → header 8'h12; bit 47 = 1; done again; seq reads 2 internally.
- **Round-robin tie.** req_a and req_b both held from IDLE after reset → A first, then B after frame plus gap (grant 201 clocks later); B header has src=1.
- **Abort.** enable dropped during bit 20 → next edge: tx_active=0, bit_out=0; no done; next frame uses the same seq.
- **Requests during GAP.** req_b raised during GAP → no ack until GAP expires; ack_b 9 edges after done.
- **Async reset mid-frame.** reset asserted during bit 30 → all outputs 0 immediately; after release, the next frame has seq=0 and A priority.

Source files
------------

// File: rtl/hitchhike_tx_sched.sv
// hitchhike_tx_sched: round-robin frame scheduler and bit serializer.
// Optional build macro TX_PARITY_EN puts even parity in frame bit 47.
module hitchhike_tx_sched #(
  parameter int unsigned BIT_PERIOD = 50,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_req_a,
  input  logic [9:0] i_data_a,
  input  logic       i_req_b,
  input  logic [9:0] i_data_b,
  output logic       o_ack_a,
  output logic       o_ack_b,
  output logic       o_bit_out,
  output logic       o_bit_strobe,
  output logic       o_tx_active,
  output logic       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  localparam logic [15:0] LP_BIT_LAST =
    16'(BIT_PERIOD - 1);
  localparam logic [15:0] LP_GAP_LAST =
    16'(GAP_CYCLES - 1);
  localparam logic [23:0] LP_PREAMBLE = 24'h929292;
  localparam logic [5:0]  LP_IDX_LAST = 6'd47;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_gap;
  logic [5:0]  r_idx;
  logic [2:0]  r_seq;
  logic        r_rr_last;
  logic        r_src;
  logic [9:0]  r_payload;
  logic        r_ack_a;
  logic        r_ack_b;
  logic        r_done;

  state_t      w_state;
  logic [15:0] w_cnt;
  logic [15:0] w_gap;
  logic [5:0]  w_idx;
  logic [2:0]  w_seq;
  logic        w_rr_last;
  logic        w_src;
  logic [9:0]  w_payload;
  logic        w_ack_a;
  logic        w_ack_b;
  logic        w_done;

  logic        w_grant_a;
  logic        w_grant_b;
  logic [7:0]  w_header;
  logic        w_parity;
  logic [5:0]  w_tail;
  logic [47:0] w_frame;
  logic        w_bit_sel;
  logic        w_active;

  // rr_last = 1 means B was served last, so A wins a tie
  assign w_grant_a = i_enable & i_req_a &
                     (~i_req_b | r_rr_last);
  assign w_grant_b = i_enable & i_req_b &
                     (~i_req_a | ~r_rr_last);

  assign w_header = {r_src, r_seq, 4'b0010};
  assign w_parity = ^{w_header, r_payload};
`ifdef TX_PARITY_EN
  assign w_tail   = {5'b00000, w_parity};
`else
  assign w_tail   = 6'b000000;
`endif
  assign w_frame  = {LP_PREAMBLE, w_header,
                     r_payload, w_tail};
  assign w_bit_sel = w_frame[LP_IDX_LAST - r_idx];

  assign w_active     = (r_state == ST_SEND);
  assign o_tx_active  = w_active;
  assign o_bit_strobe = w_active & (r_cnt == 16'd0);
  assign o_bit_out    = w_active & w_bit_sel;
  assign o_ack_a      = r_ack_a;
  assign o_ack_b      = r_ack_b;
  assign o_done       = r_done;

  // State register and frame context
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_idx     <= '0;
      r_seq     <= '0;
      r_rr_last <= 1'b1;
      r_src     <= 1'b0;
      r_payload <= '0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_gap     <= w_gap;
      r_idx     <= w_idx;
      r_seq     <= w_seq;
      r_rr_last <= w_rr_last;
      r_src     <= w_src;
      r_payload <= w_payload;
      r_ack_a   <= w_ack_a;
      r_ack_b   <= w_ack_b;
      r_done    <= w_done;
    end
  end

  // Next-state: grant, serialize, gap; enable low aborts
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_gap     = r_gap;
    w_idx     = r_idx;
    w_seq     = r_seq;
    w_rr_last = r_rr_last;
    w_src     = r_src;
    w_payload = r_payload;
    w_ack_a   = 1'b0;
    w_ack_b   = 1'b0;
    w_done    = 1'b0;
    if (!i_enable) begin
      w_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_a | w_grant_b) begin
            w_state   = ST_SEND;
            w_cnt     = '0;
            w_idx     = '0;
            w_src     = w_grant_b;
            w_rr_last = w_grant_b;
            w_payload = w_grant_b ? i_data_b
                                  : i_data_a;
            w_ack_a   = w_grant_a;
            w_ack_b   = w_grant_b;
          end
        end
        ST_SEND: begin
          if (r_cnt == LP_BIT_LAST) begin
            w_cnt = '0;
            if (r_idx == LP_IDX_LAST) begin
              w_state = ST_GAP;
              w_gap   = '0;
              w_done  = 1'b1;
              w_seq   = r_seq + 3'd1;
            end else begin
              w_idx = r_idx + 6'd1;
            end
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (r_gap == LP_GAP_LAST) begin
            w_state = ST_IDLE;
          end else begin
            w_gap = r_gap + 16'd1;
          end
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hitchhike_tx_sched.sv
// tb_hitchhike_tx_sched: directed bench for the frame scheduler.
// Frames are hand-written 48-bit constants, bit 0 in the MSB.
module tb_hitchhike_tx_sched;

  localparam int BP = 4;
  localparam int GC = 8;

`ifdef TX_PARITY_EN
  localparam logic LP_PAR = 1'b1;
`else
  localparam logic LP_PAR = 1'b0;
`endif

  localparam logic [47:0] F_A0 = 48'h929292_02_AA80;
  localparam logic [47:0] F_A1 =
    48'h929292_12_0040 | {47'd0, LP_PAR};
  localparam logic [47:0] F_B2 = 48'h929292_A2_5540;
  localparam logic [47:0] F_B1 =
    48'h929292_92_3C00 | {47'd0, LP_PAR};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       req_a = 1'b0;
  logic [9:0] data_a = '0;
  logic       req_b = 1'b0;
  logic [9:0] data_b = '0;
  logic       ack_a;
  logic       ack_b;
  logic       bit_out;
  logic       strobe;
  logic       tx_active;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  hitchhike_tx_sched #(
    .BIT_PERIOD(BP),
    .GAP_CYCLES(GC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_req_a      (req_a),
    .i_data_a     (data_a),
    .i_req_b      (req_b),
    .i_data_b     (data_b),
    .o_ack_a      (ack_a),
    .o_ack_b      (ack_b),
    .o_bit_out    (bit_out),
    .o_bit_strobe (strobe),
    .o_tx_active  (tx_active),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after the grant edge; leaves #1 after done edge
  task automatic run_frame(input string tag,
                           input logic [47:0] exp_bits);
    logic [47:0] bits;
    logic        first;
    int          strobes;
    int          bad_strobe;
    int          unstable;
    int          inactive;
    int          early_done;
    bits = '0;
    first = 1'b0;
    strobes = 0;
    bad_strobe = 0;
    unstable = 0;
    inactive = 0;
    early_done = 0;
    for (int c = 0; c < 48 * BP; c++) begin
      if (c % BP == 0) begin
        bits  = {bits[46:0], bit_out};
        first = bit_out;
      end else if (bit_out !== first) begin
        unstable++;
      end
      if (strobe) begin
        strobes++;
        if (c % BP != 0) bad_strobe++;
      end
      if (!tx_active) inactive++;
      if (done) early_done++;
      tick();
    end
    check({tag, " bits"}, 64'(bits), 64'(exp_bits));
    check({tag, " strobes"}, 64'(strobes), 64'd48);
    check({tag, " strobe pos"}, 64'(bad_strobe), 64'd0);
    check({tag, " bit hold"}, 64'(unstable), 64'd0);
    check({tag, " active"}, 64'(inactive), 64'd0);
    check({tag, " early done"}, 64'(early_done), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " end out"},
          64'({tx_active, bit_out, strobe}), 64'd0);
  endtask

  // Entered #1 after done edge with request already raised
  task automatic gap_grant(input string tag,
                           input bit want_b);
    int acks;
    acks = 0;
    for (int j = 1; j <= GC; j++) begin
      tick();
      if (j == 1) check({tag, " done pulse"},
                        64'(done), 64'd0);
      if (ack_a | ack_b) acks++;
    end
    check({tag, " gap no ack"}, 64'(acks), 64'd0);
    tick();
    check({tag, " gap ack"}, 64'({ack_a, ack_b}),
          want_b ? 64'd1 : 64'd2);
    check({tag, " start"},
          64'({tx_active, strobe, bit_out}), 64'd7);
  endtask

  initial begin
    int quiet;
    #23;
    check("reset outs",
          64'({ack_a, ack_b, bit_out, strobe,
               tx_active, done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_a = 1'b1;
    data_a = 10'h2AA;
    tick();
    check("a0 ack", 64'({ack_a, ack_b}), 64'd2);
    check("a0 start",
          64'({tx_active, strobe, bit_out}), 64'd7);
    req_a = 1'b0;
    run_frame("a0", F_A0);

    req_a = 1'b1;
    data_a = 10'h001;
    gap_grant("a1", 1'b0);
    req_a = 1'b0;
    run_frame("a1", F_A1);

    req_b = 1'b1;
    data_b = 10'h155;
    gap_grant("b2", 1'b1);
    req_b = 1'b0;
    for (int c = 0; c < 20 * BP + 1; c++) tick();
    check("abort pre", 64'(tx_active), 64'd1);
    enable = 1'b0;
    tick();
    check("abort outs",
          64'({tx_active, bit_out, strobe}), 64'd0);
    quiet = 0;
    for (int c = 0; c < 12; c++) begin
      if (done | ack_a | ack_b) quiet++;
      tick();
    end
    check("abort quiet", 64'(quiet), 64'd0);
    enable = 1'b1;
    req_b = 1'b1;
    tick();
    check("b2r ack", 64'({ack_a, ack_b}), 64'd1);
    req_b = 1'b0;
    run_frame("b2r", F_B2);

    req_a = 1'b1;
    data_a = 10'h2AA;
    gap_grant("a3", 1'b0);
    req_a = 1'b0;
    for (int c = 0; c < 30 * BP + 1; c++) tick();
    check("rst pre", 64'(tx_active), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async",
          64'({ack_a, ack_b, bit_out, strobe,
               tx_active, done}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    data_a = 10'h2AA;
    data_b = 10'h0F0;
    tick();
    check("tie ack", 64'({ack_a, ack_b}), 64'd2);
    req_a = 1'b0;
    run_frame("tie a", F_A0);
    gap_grant("tie b", 1'b1);
    req_b = 1'b0;
    run_frame("tie b", F_B1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
